// File: rtl/afifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one async-FIFO write port.
// Grant is held until the owner's last beat or MAX_BURST beats.
module afifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NREQ       = 4,
   parameter int MAX_BURST  = 16
) (
   input  logic                       wclk,
   input  logic                       w_nrst,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*DATA_WIDTH-1:0] req_data,
   input  logic [NREQ-1:0]            req_last,
   output logic [NREQ-1:0]            req_ready,
   input  logic                       full,
   output logic                       winc,
   output logic [DATA_WIDTH-1:0]      wdata,
   output logic [$clog2(NREQ)-1:0]    grant_id,
   output logic                       busy
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(MAX_BURST) + 1;

   typedef enum logic {
      IDLE,
      LOCK
   } state_t;

   state_t        state;
   logic [IW-1:0] owner;
   logic [IW-1:0] last_owner;
   logic [CW-1:0] beat_cnt;

   logic [IW-1:0] pick;
   logic          pick_hit;
   logic          xfer;
   logic          last_beat;

   // first valid requester after the previous owner, wrapping
   always_comb begin
      pick     = '0;
      pick_hit = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!pick_hit &&
             req_valid[(int'(last_owner) + k) % NREQ]) begin
            pick_hit = 1'b1;
            pick     = IW'((int'(last_owner) + k) % NREQ);
         end
      end
   end

   assign xfer = (state == LOCK) & req_valid[owner] & ~full;

   assign last_beat = req_last[owner] |
                      (beat_cnt == CW'(MAX_BURST - 1));

   assign winc     = xfer;
   assign busy     = (state == LOCK);
   assign grant_id = owner;

   // owner's data steered onto the write port only while locked
   always_comb begin
      wdata = '0;
      if (state == LOCK) begin
         wdata = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // only the owner sees ready, and only on an accepted beat
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = xfer & (owner == IW'(i));
      end
   end

   // arbitration and burst-lock state machine
   always_ff @(posedge wclk or negedge w_nrst) begin
      if (!w_nrst) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= IW'(NREQ - 1);
         beat_cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_hit) begin
                  owner    <= pick;
                  beat_cnt <= '0;
                  state    <= LOCK;
               end
            end
            LOCK: begin
               if (xfer) begin
                  if (last_beat) begin
                     state      <= IDLE;
                     last_owner <= owner;
                     beat_cnt   <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
